pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Sequences the PLL that sits between the 24 MHz crystal and the system clock network.
- Holds the PLL in reset, waits for a stable lock and retries on timeout, then releases a synchronously-deasserted system reset.
- Watches for lock loss in service, re-sequences on loss, and latches fault/diagnostic status.
- Clocked from the globally buffered crystal clock, which is never the PLL output, so it keeps running while the PLL is unlocked.

Parameters:
- PLL_RST_CYCLES, 24: cycles RESETB is held low per attempt (1 us at 24 MHz).
- LOCK_TIMEOUT, 2400: cycles to wait for lock before retrying (100 us).
- LOCK_STABLE, 240: consecutive synced-lock-high cycles required before release (10 us).
- RST_HOLD, 16: cycles o_sys_rst stays high after lock is declared stable.
- MAX_RETRIES, 7: lock timeouts tolerated before FAULT; 4-bit max.

Ports:
- i_sys_clk, in, 1: buffered crystal clock; the only clock.
- i_rst, in, 1: asynchronous, active-high reset.
- i_pll_lock, in, 1: raw PLL LOCK, asynchronous to i_sys_clk.
- i_restart, in, 1: single-cycle pulse; forces a full re-sequence and clears status.
- o_pll_resetb, out, 1: to PLL RESETB; low holds the PLL in reset.
- o_sys_rst, out, 1: active-high system reset; asserts immediately, deasserts synchronously.
- o_ready, out, 1: high only in RUN.
- o_lock_lost, out, 1: sticky; set on lock loss while in RUN.
- o_fault, out, 1: high in FAULT.
- o_retry_count, out, 4: lock timeouts since reset or restart; saturating.
- o_state, out, 3: current state encoding, for debug LEDs.

Behaviour:
- Reset values while i_rst is high: o_pll_resetb=0, o_sys_rst=1, o_ready=0, o_lock_lost=0, o_fault=0, o_retry_count=0, state=PLL_RESET, all counters 0.
- Reset may assert mid-operation in any state; it takes effect asynchronously with the values above.
- i_pll_lock passes through a 2-flop synchronizer to produce lock_s (2-cycle latency). No other logic samples i_pll_lock.
- One down-counter, width = clog2 of the largest timing parameter, is reloaded on every state entry.
- States (encoding): PLL_RESET=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAULT=5.
- PLL_RESET:
  - o_pll_resetb=0, o_sys_rst=1.
  - Stays exactly PLL_RST_CYCLES cycles, then goes to WAIT_LOCK.
- WAIT_LOCK:
  - o_pll_resetb=1.
  - lock_s=1 -> STABLE.
  - Counter expiry after LOCK_TIMEOUT cycles -> o_retry_count +1 (saturating at 15).
  - On expiry, if the new count >= MAX_RETRIES -> FAULT, else -> PLL_RESET.
- STABLE:
  - lock_s=0 on any cycle -> WAIT_LOCK, with the timeout counter reloaded and no retry increment.
  - LOCK_STABLE consecutive cycles of lock_s=1 -> RELEASE.
- RELEASE:
  - o_sys_rst stays 1 for RST_HOLD cycles.
  - lock_s=0 on any cycle -> PLL_RESET; o_lock_lost is not set.
  - On exit to RUN, o_sys_rst falls on the same clock edge that o_ready rises.
- RUN:
  - o_sys_rst=0, o_ready=1.
  - Lock loss = lock_s low on 2 consecutive cycles; a single low cycle is ignored as a glitch.
  - On lock loss, at the next edge: o_sys_rst=1, o_ready=0, o_lock_lost=1, state -> PLL_RESET. o_retry_count is unchanged.
- FAULT:
  - o_pll_resetb=0, o_sys_rst=1, o_fault=1.
  - Terminal until i_rst or i_restart.
- i_restart:
  - Honoured in any state, and takes priority over all same-cycle transitions.
  - Next state PLL_RESET; clears o_retry_count, o_lock_lost and o_fault.
  - o_sys_rst asserts on the next edge.
- o_sys_rst and o_pll_resetb are driven directly from flops, never from combinational decode.

Decomposition:
- Package pll_seq_pkg holds:
  - the state enum with the fixed encoding above;
  - default timing constants;
  - a clog2-based counter-width function.
- One sub-module, sync_2ff: a generic 2-flop synchronizer with asynchronous reset to 0, used for i_pll_lock.

Test Plan:
- Lock never asserts -> o_pll_resetb pulses low 24 cycles per attempt; o_retry_count steps 1..7; o_fault=1 after the 7th timeout (~7×2424 cycles); o_sys_rst held 1 throughout.
- Lock rises at cycle 100 and stays high -> STABLE entered at ~cycle 102; RELEASE after 240 more cycles; o_sys_rst falls and o_ready rises together 16 cycles later; o_retry_count=0.
- In STABLE, drop lock for 1 cycle at stable-count 200 -> back to WAIT_LOCK, no retry increment, STABLE count restarts from 0 on relock.
- In RUN, drop lock for 1 cycle -> no change. Drop for 3 cycles -> o_sys_rst=1, o_ready=0, o_lock_lost=1, state=0; the sequence then completes again and o_lock_lost stays 1.
- From FAULT, pulse i_restart -> o_fault=0, o_retry_count=0, o_pll_resetb low for 24 cycles. Also pulse i_restart in RUN -> o_sys_rst=1 on the next edge.
- Assert i_rst asynchronously mid-RELEASE -> outputs take reset values before the next clock edge; normal sequencing resumes after release.

Source files
------------

// File: rtl/pll_reset_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pll_seq_pkg: state encoding, default timing and counter sizing helper.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package pll_seq_pkg;

    localparam int unsigned DEF_PLL_RST_CYCLES = 24;
    localparam int unsigned DEF_LOCK_TIMEOUT   = 2400;
    localparam int unsigned DEF_LOCK_STABLE    = 240;
    localparam int unsigned DEF_RST_HOLD       = 16;
    localparam int unsigned DEF_MAX_RETRIES    = 7;

    localparam int unsigned RETRY_W = 4;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 32'd1 : 32'($clog2(m));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_reset_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pll_reset_sequencer_if: PLL control/status bundle of the reset sequencer.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface pll_reset_sequencer_if;
    import pll_seq_pkg::*;

    logic               i_pll_lock;
    logic               i_restart;
    logic               o_pll_resetb;
    logic               o_sys_rst;
    logic               o_ready;
    logic               o_lock_lost;
    logic               o_fault;
    logic [RETRY_W-1:0] o_retry_count;
    logic [STATE_W-1:0] o_state;

    modport master (
        input  i_pll_lock, i_restart,
        output o_pll_resetb, o_sys_rst, o_ready, o_lock_lost, o_fault, o_retry_count, o_state
    );

    modport slave (
        output i_pll_lock, i_restart,
        input  o_pll_resetb, o_sys_rst, o_ready, o_lock_lost, o_fault, o_retry_count, o_state
    );

endinterface
`default_nettype wire

// File: rtl/pll_reset_sequencer_sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_2ff: two-flop synchronizer, asynchronous reset to 0.                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  wire              i_clk,
    input  wire              i_rst,
    input  wire  [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q <= '0;
            o_q    <= '0;
        end else begin
            meta_q <= i_d;
            o_q    <= meta_q;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pll_reset_sequencer: PLL reset/lock sequencing and system reset release.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int unsigned LOCK_STABLE    = DEF_LOCK_STABLE,
    parameter int unsigned RST_HOLD       = DEF_RST_HOLD,
    parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  wire                   i_sys_clk,
    input  wire                   i_rst,
    pll_reset_sequencer_if.master bus
);

    localparam int unsigned CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, RST_HOLD);

    // The counter is reloaded with 0 on entry and counts down, so the value after
    // N-1 cycles in a state is -(N-1); reset and state entry share the same load.
    localparam logic [CNT_W-1:0] c_rst_end     = CNT_W'(0) - CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_end = CNT_W'(0) - CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_stable_end  = CNT_W'(0) - CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] c_hold_end    = CNT_W'(0) - CNT_W'(RST_HOLD - 1);
    localparam logic [RETRY_W-1:0] c_max_retries = RETRY_W'(MAX_RETRIES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               lost_q, lost_d;
    logic               low_q, low_d;
    logic               resetb_q, sys_rst_q, ready_q, fault_q;
    logic               lock_s;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .i_clk (i_sys_clk),
        .i_rst (i_rst),
        .i_d   (bus.i_pll_lock),
        .o_q   (lock_s)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lost_d  = lost_q;
        low_d   = (state_q == ST_RUN) && !lock_s;
        if (bus.i_restart) begin
            state_d = ST_PLL_RESET;
            retry_d = '0;
            lost_d  = 1'b0;
        end else begin
            case (state_q)
                ST_PLL_RESET: if (cnt_q == c_rst_end) state_d = ST_WAIT_LOCK;
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                    end else if (cnt_q == c_timeout_end) begin
                        retry_d = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
                        state_d = (retry_d >= c_max_retries) ? ST_FAULT : ST_PLL_RESET;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s)                    state_d = ST_WAIT_LOCK;
                    else if (cnt_q == c_stable_end) state_d = ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!lock_s)                  state_d = ST_PLL_RESET;
                    else if (cnt_q == c_hold_end) state_d = ST_RUN;
                end
                // A single low sample in RUN is treated as a glitch.
                ST_RUN: begin
                    if (!lock_s && low_q) begin
                        state_d = ST_PLL_RESET;
                        lost_d  = 1'b1;
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_PLL_RESET;
            endcase
        end
        cnt_d = (bus.i_restart || (state_d != state_q)) ? '0 : cnt_q - CNT_W'(1);
    end

    // Output flops are loaded from the next state so they track state_q exactly.
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_PLL_RESET;
            cnt_q     <= '0;
            retry_q   <= '0;
            lost_q    <= 1'b0;
            low_q     <= 1'b0;
            resetb_q  <= 1'b0;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            lost_q    <= lost_d;
            low_q     <= low_d;
            resetb_q  <= !((state_d == ST_PLL_RESET) || (state_d == ST_FAULT));
            sys_rst_q <= (state_d != ST_RUN);
            ready_q   <= (state_d == ST_RUN);
            fault_q   <= (state_d == ST_FAULT);
        end
    end

    assign bus.o_pll_resetb  = resetb_q;
    assign bus.o_sys_rst     = sys_rst_q;
    assign bus.o_ready       = ready_q;
    assign bus.o_lock_lost   = lost_q;
    assign bus.o_fault       = fault_q;
    assign bus.o_retry_count = retry_q;
    assign bus.o_state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pll_reset_sequencer: randomized bench against a behavioural model.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_pll_reset_sequencer;

    localparam int PRC = 24;
    localparam int LT  = 2400;
    localparam int LS  = 240;
    localparam int RH  = 16;
    localparam int MR  = 7;

    // Phase numbers as listed for the debug output.
    localparam int P_RESET = 0, P_WAIT = 1, P_STABLE = 2, P_RELEASE = 3, P_RUN = 4, P_FAULT = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    pll_reset_sequencer_if bus();

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (PRC),
        .LOCK_TIMEOUT   (LT),
        .LOCK_STABLE    (LS),
        .RST_HOLD       (RH),
        .MAX_RETRIES    (MR)
    ) dut (
        .i_sys_clk (clk),
        .i_rst     (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int m_ph, m_el, m_retry, m_runlow;
    bit m_lost, m_s1, m_s2;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] m_vec();
        return {(m_ph != P_RESET && m_ph != P_FAULT), (m_ph != P_RUN), (m_ph == P_RUN),
                m_lost, (m_ph == P_FAULT), 4'(m_retry), 3'(m_ph)};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {bus.o_pll_resetb, bus.o_sys_rst, bus.o_ready, bus.o_lock_lost,
                bus.o_fault, bus.o_retry_count, bus.o_state};
    endfunction

    task automatic model_reset();
        m_ph = P_RESET; m_el = 0; m_retry = 0; m_runlow = 0;
        m_lost = 0; m_s1 = 0; m_s2 = 0;
    endtask

    // One clock edge: m_el counts whole cycles already spent in the phase.
    task automatic model_edge(input bit lock, input bit restart);
        bit ls;
        int nxt;
        ls = m_s2; m_s2 = m_s1; m_s1 = lock;
        nxt = m_ph;
        if (restart) begin
            nxt = P_RESET; m_retry = 0; m_lost = 0;
        end else if (m_ph == P_RESET) begin
            if (m_el + 1 == PRC) nxt = P_WAIT;
        end else if (m_ph == P_WAIT) begin
            if (ls) nxt = P_STABLE;
            else if (m_el + 1 == LT) begin
                m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                nxt = (m_retry >= MR) ? P_FAULT : P_RESET;
            end
        end else if (m_ph == P_STABLE) begin
            if (!ls) nxt = P_WAIT;
            else if (m_el + 1 == LS) nxt = P_RELEASE;
        end else if (m_ph == P_RELEASE) begin
            if (!ls) nxt = P_RESET;
            else if (m_el + 1 == RH) nxt = P_RUN;
        end else if (m_ph == P_RUN) begin
            if (!ls && m_runlow >= 1) begin nxt = P_RESET; m_lost = 1; end
        end
        m_runlow = (m_ph == P_RUN && !ls) ? m_runlow + 1 : 0;
        m_el = (restart || nxt != m_ph) ? 0 : m_el + 1;
        m_ph = nxt;
    endtask

    task automatic step(input bit lock, input bit restart);
        bus.i_pll_lock = lock;
        bus.i_restart  = restart;
        @(posedge clk);
        model_edge(lock, restart);
        #1;
        check("cycle", 32'(dut_vec()), 32'(m_vec()));
    endtask

    task automatic run_until(input bit lock, input int target, input int max_cyc, input string tag);
        int n;
        n = 0;
        while (m_ph != target && n < max_cyc) begin
            step(lock, 1'b0);
            n++;
        end
        check(tag, 32'(bus.o_state), 32'(target));
    endtask

    initial begin
        int d;
        int dip;
        bus.i_pll_lock = 1'b0;
        bus.i_restart  = 1'b0;
        #1 rst = 1'b1;
        #1 check("rst_vals", 32'(dut_vec()), 32'h400);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Lock never comes: seven timeouts then FAULT.
        run_until(1'b0, P_FAULT, 8 * (PRC + LT), "fault_reached");
        check("fault_retry", 32'(bus.o_retry_count), 32'(MR));
        check("fault_flag", 32'(bus.o_fault), 32'd1);
        check("fault_sysrst", 32'(bus.o_sys_rst), 32'd1);
        repeat (20) step(1'b0, 1'b0);

        // Restart out of FAULT, lock arrives at a random time.
        step(1'b0, 1'b1);
        check("restart_clr", 32'({bus.o_fault, bus.o_retry_count, bus.o_pll_resetb}), 32'd0);
        d = $urandom_range(40, 160);
        repeat (d) step(1'b0, 1'b0);
        run_until(1'b1, P_RUN, 3000, "run_reached");
        check("run_retry0", 32'(bus.o_retry_count), 32'd0);

        // Lock glitch in STABLE at stable-count 200.
        step(1'b1, 1'b1);
        repeat (30) step(1'b0, 1'b0);
        run_until(1'b1, P_STABLE, 3000, "stable_entered");
        d = 0;
        while (m_el < 200 && d < 400) begin step(1'b1, 1'b0); d++; end
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("stable_drop", 32'(bus.o_state), 32'(P_WAIT));
        run_until(1'b1, P_RUN, 3000, "run_after_glitch");
        check("glitch_retry", 32'(bus.o_retry_count), 32'd0);

        // RUN: one-cycle dip ignored, three-cycle dip is a loss.
        step(1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b0);
        check("dip1_ready", 32'(bus.o_ready), 32'd1);
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("loss", 32'({bus.o_ready, bus.o_sys_rst, bus.o_lock_lost, bus.o_state}), 32'h18);
        run_until(1'b1, P_RUN, 3000, "resequenced");
        check("lost_sticky", 32'(bus.o_lock_lost), 32'd1);

        // Restart from RUN.
        step(1'b1, 1'b1);
        check("restart_run", 32'({bus.o_sys_rst, bus.o_ready, bus.o_lock_lost}), 32'h4);

        // Asynchronous reset in the middle of RELEASE.
        run_until(1'b1, P_RELEASE, 3000, "release_reached");
        d = $urandom_range(1, 10);
        repeat (d) step(1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 check("async_rst", 32'(dut_vec()), 32'h400);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        run_until(1'b1, P_RUN, 3000, "run_after_rst");

        // Random soak: dips of 1..4 cycles and rare restarts.
        dip = 0;
        for (int i = 0; i < 4000; i++) begin
            bit r;
            r = ($urandom_range(0, 599) == 0);
            if (dip == 0 && $urandom_range(0, 79) == 0) dip = $urandom_range(1, 4);
            if (dip > 0) begin
                step(1'b0, r);
                dip--;
            end else begin
                step(1'b1, r);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
